// File: rtl/noc_axi4_ser_pkg.sv
// noc_axi4_ser_pkg: NoC header layout, message codes and serializer helper functions
package noc_axi4_ser_pkg;

    localparam int MSG_HEADER_WIDTH = 192;
    localparam int NOC_WIDTH_DEF    = 64;
    localparam int MAX_NOC_WIDTH    = 512;

    localparam logic [7:0] MSG_NC_LOAD_REQ      = 8'd14;
    localparam logic [7:0] MSG_NC_STORE_REQ     = 8'd15;
    localparam logic [7:0] MSG_LOAD_MEM         = 8'd19;
    localparam logic [7:0] MSG_STORE_MEM        = 8'd20;
    localparam logic [7:0] MSG_LOAD_MEM_ACK     = 8'd24;
    localparam logic [7:0] MSG_STORE_MEM_ACK    = 8'd25;
    localparam logic [7:0] MSG_NC_LOAD_MEM_ACK  = 8'd26;
    localparam logic [7:0] MSG_NC_STORE_MEM_ACK = 8'd27;

    // Request header: src chip/x/y/fbits contiguous in the top flit
    localparam int SRC_HI    = 191;
    localparam int SRC_LO    = 158;
    localparam int SIZE_HI   = 114;
    localparam int SIZE_LO   = 112;
    localparam int TYPE_HI   = 21;
    localparam int TYPE_LO   = 14;
    localparam int MSHR_HI   = 13;
    localparam int MSHR_LO   = 6;
    localparam int SRC_W     = SRC_HI - SRC_LO + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA} ser_state_e;

    typedef struct packed {
        logic [7:0] msg_type;
        logic [7:0] len;
        logic       drop;
    } resp_info_t;

    function automatic logic [2:0] noc_extract_size(input logic [2:0] sz);
        return (sz == 3'd0) ? 3'd0 : sz - 3'd1;
    endfunction

    function automatic resp_info_t resp_type_len(input logic [7:0] msg_type, input logic [2:0] size_log,
                                                 input int beats, input int fbl);
        resp_info_t r;
        int nc_len;
        nc_len = (int'(size_log) > fbl) ? (1 << (int'(size_log) - fbl)) : 1;
        nc_len = (nc_len > beats) ? beats : nc_len;
        r = '{8'd0, 8'd0, 1'b1};
        if (msg_type == MSG_LOAD_MEM)     r = '{MSG_LOAD_MEM_ACK, 8'(beats), 1'b0};
        if (msg_type == MSG_NC_LOAD_REQ)  r = '{MSG_NC_LOAD_MEM_ACK, 8'(nc_len), 1'b0};
        if (msg_type == MSG_STORE_MEM)    r = '{MSG_STORE_MEM_ACK, 8'd0, 1'b0};
        if (msg_type == MSG_NC_STORE_REQ) r = '{MSG_NC_STORE_MEM_ACK, 8'd0, 1'b0};
        return r;
    endfunction

    // Granules are power-of-two aligned, so reversal within one is an index XOR
    function automatic logic [MAX_NOC_WIDTH-1:0] swap_flit(input logic [MAX_NOC_WIDTH-1:0] flit,
                                                           input logic [2:0] size_log, input int fbl);
        logic [MAX_NOC_WIDTH-1:0] r;
        int m;
        m = (1 << ((int'(size_log) < fbl) ? int'(size_log) : fbl)) - 1;
        r = '0;
        for (int i = 0; i < MAX_NOC_WIDTH / 8; i++)
            if (i < (1 << fbl)) r[i*8 +: 8] = flit[(i ^ m)*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/noc_axi4_resp_fifo.sv
// noc_axi4_resp_fifo: synchronous FIFO with occupancy count
module noc_axi4_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= bump(wr_ptr_q);
            if (rd_en) rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/noc_axi4_resp_serializer.sv
// noc_axi4_resp_serializer: queues completed AXI transactions and emits NoC response packets
module noc_axi4_resp_serializer
    import noc_axi4_ser_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int NOC_DATA_WIDTH = NOC_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 2,
    parameter int SWAP_ENDIANESS = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [MSG_HEADER_WIDTH-1:0]     header_in,
    input  logic [AXI_DATA_WIDTH-1:0]       data_in,
    input  logic                            in_val,
    output logic                            in_rdy,
    output logic [NOC_DATA_WIDTH-1:0]       flit_out,
    output logic                            flit_out_val,
    input  logic                            flit_out_rdy,
    output logic                            drop_pulse,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] q_count
);
    localparam int BEATS = AXI_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int FBL   = $clog2(NOC_DATA_WIDTH / 8);
    localparam int QW    = $clog2(FIFO_DEPTH + 1);
    localparam int EW    = SRC_W + 8 + 8 + 3 + AXI_DATA_WIDTH;

    ser_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;

    logic                      in_go, pop, more, unused_hdr;
    logic [EW-1:0]             head;
    logic [SRC_W-1:0]          h_src;
    logic [7:0]                h_mshr, h_type;
    logic [2:0]                h_size, size_log;
    logic [AXI_DATA_WIDTH-1:0] h_data;
    logic [NOC_DATA_WIDTH-1:0] raw_flit, data_flit;
    logic [MAX_NOC_WIDTH-1:0]  sw_wide;
    logic [63:0]               resp_hdr;
    resp_info_t                info;

    assign in_rdy     = rst_n && (q_count < QW'(FIFO_DEPTH));
    assign in_go      = in_val && in_rdy;
    assign unused_hdr = ^header_in;

    // Only the fields the response needs are queued
    noc_axi4_resp_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_go),
        .wr_data ({header_in[SRC_HI:SRC_LO], header_in[MSHR_HI:MSHR_LO], header_in[TYPE_HI:TYPE_LO],
                   header_in[SIZE_HI:SIZE_LO], data_in}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (q_count)
    );

    assign {h_src, h_mshr, h_type, h_size, h_data} = head;
    assign size_log  = noc_extract_size(h_size);
    assign info      = resp_type_len(h_type, size_log, BEATS, FBL);
    assign resp_hdr  = {h_src, info.len, info.msg_type, h_mshr, 6'd0};
    assign raw_flit  = h_data[int'(k_q) * NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
    assign sw_wide   = swap_flit(MAX_NOC_WIDTH'(raw_flit), size_log, FBL);
    assign data_flit = (SWAP_ENDIANESS != 0) ? sw_wide[NOC_DATA_WIDTH-1:0] : raw_flit;
    // An entry written this cycle is the next head, so it counts as remaining
    assign more      = (q_count > QW'(1)) || in_go;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        pop          = 1'b0;
        drop_pulse   = 1'b0;
        flit_out_val = 1'b0;
        flit_out     = '0;
        case (state_q)
            IDLE: state_d = (q_count != '0) ? HDR : IDLE;
            HDR: begin
                drop_pulse   = info.drop;
                flit_out_val = !info.drop;
                flit_out     = NOC_DATA_WIDTH'(resp_hdr);
                if (info.drop || flit_out_rdy) begin
                    if (info.drop || info.len == 8'd0) begin
                        pop     = 1'b1;
                        state_d = more ? HDR : IDLE;
                    end else begin
                        cnt_d   = CW'(info.len);
                        k_d     = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                flit_out_val = 1'b1;
                flit_out     = data_flit;
                if (flit_out_rdy) begin
                    cnt_d = cnt_q - CW'(1);
                    k_d   = k_q + KW'(1);
                    if (cnt_q == CW'(1)) begin
                        pop     = 1'b1;
                        state_d = more ? HDR : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_noc_axi4_resp_serializer.sv
// tb_noc_axi4_resp_serializer: directed and random checks of plain and byte-swapping serializers
module tb_noc_axi4_resp_serializer;

    localparam logic [7:0] T_NC_LOAD = 8'd14, T_NC_STORE = 8'd15, T_LOAD = 8'd19, T_STORE = 8'd20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [191:0] header_in = '0;
    logic [511:0] data_in = '0;
    logic         in_val = 1'b0;
    logic         flit_out_rdy = 1'b1;
    logic         rdy_mode = 1'b0;
    logic         in_rdy, in_rdy_s, val0, val1, drop0, drop1;
    logic [63:0]  flit0, flit1;
    logic [1:0]   q_count, q_count_s;

    logic [63:0] fo [2];
    logic        fv [2];
    logic        dp [2];
    logic [63:0] expq [2][$];
    logic [63:0] pf [2];
    logic [63:0] last [2];
    logic        hold [2];
    int          acc [2];
    int          drops [2];
    int          exp_drops = 0;
    int          errors = 0;
    int          checks = 0;

    noc_axi4_resp_serializer #(.AXI_DATA_WIDTH(512), .NOC_DATA_WIDTH(64), .FIFO_DEPTH(2), .SWAP_ENDIANESS(0)) dut (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in), .in_val(in_val), .in_rdy(in_rdy),
        .flit_out(flit0), .flit_out_val(val0), .flit_out_rdy(flit_out_rdy), .drop_pulse(drop0), .q_count(q_count));

    noc_axi4_resp_serializer #(.AXI_DATA_WIDTH(512), .NOC_DATA_WIDTH(64), .FIFO_DEPTH(2), .SWAP_ENDIANESS(1)) dut_sw (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in), .in_val(in_val), .in_rdy(in_rdy_s),
        .flit_out(flit1), .flit_out_val(val1), .flit_out_rdy(flit_out_rdy), .drop_pulse(drop1), .q_count(q_count_s));

    assign fo[0] = flit0;
    assign fo[1] = flit1;
    assign fv[0] = val0;
    assign fv[1] = val1;
    assign dp[0] = drop0;
    assign dp[1] = drop1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pclk();
        @(posedge clk);
        #1;
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [191:0] mk_hdr(input logic [7:0] typ, input logic [2:0] sz, input logic [13:0] chip,
                                            input logic [7:0] x, input logic [7:0] y, input logic [3:0] fb,
                                            input logic [7:0] mshr);
        logic [191:0] h;
        for (int i = 0; i < 6; i++) h[i*32 +: 32] = $urandom;
        h[191:158] = {chip, x, y, fb};
        h[114:112] = sz;
        h[21:14]   = typ;
        h[13:6]    = mshr;
        return h;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] swap_ref(input logic [63:0] f, input int bytes);
        logic [63:0] r;
        int g;
        g = (bytes < 8) ? bytes : 8;
        r = f;
        for (int grp = 0; grp < 8 / g; grp++)
            for (int j = 0; j < g; j++)
                r[(grp*g + j)*8 +: 8] = f[(grp*g + g - 1 - j)*8 +: 8];
        return r;
    endfunction

    // Reference: the packet each accepted entry must produce
    task automatic model_push(input logic [191:0] h, input logic [511:0] d);
        int sl, bytes, len;
        logic [7:0] rt;
        logic [63:0] f;
        sl    = (h[114:112] == 3'd0) ? 0 : int'(h[114:112]) - 1;
        bytes = 1 << sl;
        len   = 0;
        rt    = 8'd0;
        case (h[21:14])
            T_LOAD:     begin rt = 8'd24; len = 8; end
            T_NC_LOAD:  begin rt = 8'd26; len = (bytes + 7) / 8; end
            T_STORE:    rt = 8'd25;
            T_NC_STORE: rt = 8'd27;
            default:    rt = 8'd0;
        endcase
        if (rt == 8'd0) exp_drops++;
        else begin
            for (int u = 0; u < 2; u++) expq[u].push_back({h[191:158], 8'(len), rt, h[13:6], 6'd0});
            for (int b = 0; b < len; b++) begin
                f = d[b*64 +: 64];
                expq[0].push_back(f);
                expq[1].push_back(swap_ref(f, bytes));
            end
        end
    endtask

    task automatic push(input logic [191:0] h, input logic [511:0] d);
        int n;
        header_in = h;
        data_in   = d;
        in_val    = 1'b1;
        n = 0;
        nclk();
        while (!in_rdy && n < 200) begin
            nclk();
            n++;
        end
        chk("push_timeout", 64'(n < 200), 64'd1);
        model_push(h, d);
        pclk();
        in_val = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 3000; n++) begin
            nclk();
            if (expq[0].size() == 0 && expq[1].size() == 0 && q_count == 2'd0 && !val0 && !val1) break;
        end
        chk("drain_timeout", 64'(n < 3000), 64'd1);
        chk("drain_qcount_sw", 64'(q_count_s), 64'd0);
        chk("drain_drops0", 64'(drops[0]), 64'(exp_drops));
        chk("drain_drops1", 64'(drops[1]), 64'(exp_drops));
        pclk();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            flit_out_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) hold[u] = 1'b0;
            else begin
                if (hold[u]) begin
                    chk("hold_val", 64'(fv[u]), 64'd1);
                    chk("hold_flit", fo[u], pf[u]);
                end
                if (fv[u] && flit_out_rdy) begin
                    checks++;
                    assert (expq[u].size() != 0) else begin
                        errors++;
                        $error("FAIL extra_flit%0d: observed=%h expected=none", u, fo[u]);
                    end
                    if (expq[u].size() != 0) begin
                        chk($sformatf("flit%0d", u), fo[u], expq[u].pop_front());
                        acc[u]++;
                        last[u] = fo[u];
                    end
                end
                if (dp[u]) drops[u]++;
                hold[u] = fv[u] && !flit_out_rdy;
                pf[u]   = fo[u];
            end
        end
        if (rst_n) chk("rdy_rule", 64'(in_rdy), 64'(q_count < 2'd2));
    end

    initial begin
        int a, d;
        logic [511:0] dd;
        for (int u = 0; u < 2; u++) begin
            acc[u] = 0;
            drops[u] = 0;
            hold[u] = 1'b0;
        end
        repeat (3) pclk();
        nclk();
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_val", 64'(val0), 64'd0);
        chk("rst_flit", flit0, 64'd0);
        chk("rst_drop", 64'(drop0), 64'd0);
        chk("rst_qcount", 64'(q_count), 64'd0);
        pclk();
        rst_n = 1'b1;
        nclk();
        chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
        pclk();

        // LOAD_MEM latency and full-rate burst
        a = acc[0];
        push(mk_hdr(T_LOAD, 3'd0, 14'd1, 8'd2, 8'd3, 4'd0, 8'd5), rand512());
        nclk();
        chk("lat_c1_val", 64'(val0), 64'd0);
        chk("lat_c1_qcount", 64'(q_count), 64'd1);
        for (int c = 0; c < 9; c++) begin
            nclk();
            chk($sformatf("burst_val_c%0d", c + 2), 64'(val0), 64'd1);
        end
        nclk();
        chk("burst_end_val", 64'(val0), 64'd0);
        chk("burst_count", 64'(acc[0] - a), 64'd9);
        pclk();

        // NC_LOAD 4-byte granule swap
        dd = rand512();
        dd[63:0] = 64'h0011223344556677;
        a = acc[1];
        push(mk_hdr(T_NC_LOAD, 3'd3, 14'h2a, 8'd7, 8'd9, 4'd1, 8'd33), dd);
        wait_drain();
        chk("ncload_flits", 64'(acc[1] - a), 64'd2);
        chk("ncload_swap", last[1], 64'h3322110077665544);
        chk("ncload_plain", last[0], 64'h0011223344556677);

        // Two stores back to back
        header_in = mk_hdr(T_STORE, 3'd4, 14'd4, 8'd5, 8'd6, 4'd2, 8'd10);
        data_in = rand512();
        in_val = 1'b1;
        nclk();
        chk("st_c0_rdy", 64'(in_rdy), 64'd1);
        model_push(header_in, data_in);
        pclk();
        header_in = mk_hdr(T_STORE, 3'd2, 14'd8, 8'd9, 8'd10, 4'd3, 8'd11);
        nclk();
        chk("st_c1_rdy", 64'(in_rdy), 64'd1);
        model_push(header_in, data_in);
        pclk();
        in_val = 1'b0;
        nclk();
        chk("st_c2_val", 64'(val0), 64'd1);
        chk("st_c2_rdy", 64'(in_rdy), 64'd0);
        chk("st_c2_qcount", 64'(q_count), 64'd2);
        nclk();
        chk("st_c3_val", 64'(val0), 64'd1);
        chk("st_c3_rdy", 64'(in_rdy), 64'd1);
        nclk();
        chk("st_c4_val", 64'(val0), 64'd0);
        chk("st_c4_qcount", 64'(q_count), 64'd0);
        pclk();

        // LOAD_MEM under random back-pressure
        rdy_mode = 1'b1;
        a = acc[0];
        push(mk_hdr(T_LOAD, 3'd7, 14'd3, 8'd1, 8'd4, 4'd5, 8'd77), rand512());
        wait_drain();
        chk("stall_count", 64'(acc[0] - a), 64'd9);
        rdy_mode = 1'b0;

        // Unknown type dropped, store follows
        a = acc[0];
        d = drops[0];
        push(mk_hdr(8'hFF, 3'd4, 14'd6, 8'd6, 8'd6, 4'd6, 8'd66), rand512());
        push(mk_hdr(T_STORE, 3'd1, 14'd7, 8'd7, 8'd7, 4'd7, 8'd67), rand512());
        wait_drain();
        chk("drop_once", 64'(drops[0] - d), 64'd1);
        chk("drop_flits", 64'(acc[0] - a), 64'd1);

        // Randomized traffic
        rdy_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] t;
            int s;
            s = $urandom_range(0, 4);
            t = (s == 0) ? T_LOAD : (s == 1) ? T_NC_LOAD : (s == 2) ? T_STORE : (s == 3) ? T_NC_STORE : 8'h3C;
            repeat ($urandom_range(0, 2)) pclk();
            push(mk_hdr(t, 3'($urandom_range(0, 7)), 14'($urandom), 8'($urandom), 8'($urandom),
                        4'($urandom), 8'($urandom)), rand512());
        end
        wait_drain();
        rdy_mode = 1'b0;
        pclk();

        // Reset in the middle of a data burst
        a = acc[0];
        push(mk_hdr(T_LOAD, 3'd0, 14'd9, 8'd9, 8'd9, 4'd9, 8'd99), rand512());
        d = 0;
        while (acc[0] != a + 5 && d < 100) begin
            nclk();
            d++;
        end
        chk("mid_rst_reach", 64'(d < 100), 64'd1);
        pclk();
        rst_n = 1'b0;
        nclk();
        expq[0].delete();
        expq[1].delete();
        pclk();
        nclk();
        chk("mid_rst_val", 64'(val0), 64'd0);
        chk("mid_rst_qcount", 64'(q_count), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
        pclk();
        rst_n = 1'b1;
        a = acc[0];
        repeat (20) nclk();
        chk("mid_rst_no_residual", 64'(acc[0] - a), 64'd0);
        chk("mid_rst_idle_qcount", 64'(q_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
